// File: rtl/intdiv_sub.sv
// Signed-digit negate/pass stage: one SD2 digit in, registered (sum, tr) pair out.
// Optional macro INTDIV_SUB_HOLD_EN: when defined, sum/tr hold their value on en=0 instead of clearing.
module intdiv_sub (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sub,
  input  logic [1:0] min,
  output logic       sum,
  output logic       tr,
  output logic       valid
);

  typedef struct packed {
    logic sum;
    logic tr;
  } res_t;

  localparam res_t RES_ZERO = '{sum: 1'b0, tr: 1'b0};

  logic       dig_nz;
  logic       dig_neg;
  res_t       res_d;
  res_t       res_q;
  logic [1:0] vld_pipe;

  // Only 11 is negative; 01 and 10 both mean +1, so any set bit marks a nonzero digit.
  assign dig_nz  = |min;
  assign dig_neg = &min;

  // e = sum - 2*tr: tr is set exactly when the effective digit is -1.
  always_comb begin
    res_d     = RES_ZERO;
    res_d.sum = dig_nz;
    res_d.tr  = dig_nz & (dig_neg ^ sub);
  end

  assign vld_pipe[0] = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= RES_ZERO;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (en)
        res_q <= res_d;
`ifdef INTDIV_SUB_HOLD_EN
      else
        res_q <= res_q;
`else
      else
        res_q <= RES_ZERO;
`endif
    end
  end

  assign sum   = res_q.sum;
  assign tr    = res_q.tr;
  assign valid = vld_pipe[1];

endmodule

// File: tb/tb_intdiv_sub.sv
// Directed table-driven bench for intdiv_sub; expectations follow the en=0 mode selected by INTDIV_SUB_HOLD_EN.
module tb_intdiv_sub;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       sub = 1'b0;
  logic [1:0] min = 2'b00;
  logic       sum;
  logic       tr;
  logic       valid;

  int checks = 0;
  int errors = 0;

`ifdef INTDIV_SUB_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  intdiv_sub dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .sub  (sub),
    .min  (min),
    .sum  (sum),
    .tr   (tr),
    .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       sub;
    logic [1:0] min;
    logic       exp_sum;
    logic       exp_tr;
    logic       exp_valid;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic s, input logic [1:0] m,
                     input logic xs, input logic xt, input logic xv, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.sub = s; v.min = m;
    v.exp_sum = xs; v.exp_tr = xt; v.exp_valid = xv; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic s, input logic [1:0] m);
    @(negedge clk);
    rst = r; en = e; sub = s; min = m;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic xs, input logic xt, input logic xv);
    checks++;
    if (sum !== xs || tr !== xt || valid !== xv) begin
      errors++;
      $display("FAIL %s: got sum=%b tr=%b valid=%b, want sum=%b tr=%b valid=%b",
               nm, sum, tr, valid, xs, xt, xv);
    end
  endtask

  // Reference digit value in plain integer arithmetic.
  function automatic int eff_val(input logic s, input logic [1:0] m);
    int v;
    case (m)
      2'b11:   v = -1;
      2'b00:   v = 0;
      default: v = 1;
    endcase
    return s ? -v : v;
  endfunction

  initial begin
    // reset held two cycles with a live input that must be discarded
    add(1, 1, 0, 2'b01, 0, 0, 0, "rst_hold0");
    add(1, 1, 0, 2'b01, 0, 0, 0, "rst_hold1");
    add(0, 1, 0, 2'b01, 1, 0, 1, "rst_release");
    // pass mode
    add(0, 1, 0, 2'b00, 0, 0, 1, "pass_00");
    add(0, 1, 0, 2'b01, 1, 0, 1, "pass_01");
    add(0, 1, 0, 2'b10, 1, 0, 1, "pass_10");
    add(0, 1, 0, 2'b11, 1, 1, 1, "pass_11");
    // subtract mode
    add(0, 1, 1, 2'b00, 0, 0, 1, "sub_00");
    add(0, 1, 1, 2'b01, 1, 1, 1, "sub_01");
    add(0, 1, 1, 2'b10, 1, 1, 1, "sub_10");
    add(0, 1, 1, 2'b11, 1, 0, 1, "sub_11");
    // en gap after loading -1
    add(0, 1, 0, 2'b11, 1, 1, 1, "gap_load");
    add(0, 0, 0, 2'b01, HOLD, HOLD, 0, "gap_en0");
    add(0, 0, 1, 2'b01, HOLD, HOLD, 0, "gap_en0_again");
    add(0, 1, 1, 2'b00, 0, 0, 1, "gap_resume");
    // mid-stream reset: the reset-cycle input (+1 via sub=1,min=11) must not appear
    add(0, 1, 0, 2'b01, 1, 0, 1, "mid_pre");
    add(1, 1, 1, 2'b11, 0, 0, 0, "mid_rst");
    add(0, 1, 0, 2'b00, 0, 0, 1, "mid_post");
    add(0, 1, 0, 2'b10, 1, 0, 1, "mid_post2");
    // reset with en=0 still clears regardless of hold mode
    add(0, 1, 0, 2'b11, 1, 1, 1, "rst_en0_load");
    add(1, 0, 0, 2'b01, 0, 0, 0, "rst_en0");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].sub, vecs[i].min);
      check(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_tr, vecs[i].exp_valid);
    end

    // exhaustive {sub, min}: e = sum - 2*tr and (0,1) never appears
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 4; m++) begin
        int e;
        int got;
        e = eff_val(s[0], m[1:0]);
        step(1'b0, 1'b1, s[0], m[1:0]);
        got = int'(sum) - 2 * int'(tr);
        checks++;
        if (got != e || (sum === 1'b0 && tr === 1'b1) || valid !== 1'b1) begin
          errors++;
          $display("FAIL exh_sub%0d_min%0d: got sum=%b tr=%b valid=%b value=%0d, want value=%0d valid=1",
                   s, m, sum, tr, valid, got, e);
        end
      end
    end

    step(1'b0, 1'b0, 1'b0, 2'b00);
    check("final_en0", HOLD ? 1'b1 : 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
